// File: rtl/num_reverse_engine.sv
// num_reverse_engine: reverses the base-RADIX digits of an unsigned WIDTH-bit
// operand, e.g. 1234 -> 4321 in base 10. One digit is peeled off per STEP
// cycle, so a D-digit operand completes D+1 edges after the start is accepted.
// Arithmetic truncates to WIDTH bits at every step; ovf records whether any
// intermediate accumulator value exceeded 2^WIDTH-1.
// Optional feature macro: NUM_REV_PAL_EN adds the palindrome flag is_pal
// (the port exists in both builds and is tied low when the macro is undefined).
module num_reverse_engine #(
  parameter int WIDTH = 32,
  parameter int RADIX = 10,
  parameter int DIGW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [DIGW-1:0]  digits,
  output logic             ovf,
  output logic             is_pal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  // Five guard bits hold acc*RADIX + d for any RADIX up to 16.
  localparam int WW = WIDTH + 5;
  localparam logic [WIDTH-1:0] RADIX_N = WIDTH'(RADIX);
  localparam logic [WW-1:0]    RADIX_W = WW'(RADIX);

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] acc;
  logic [DIGW-1:0]  cnt;
  logic             ovf_r;

  logic [WIDTH-1:0] x_div;
  logic [WIDTH-1:0] x_mod;
  logic [WW-1:0]    wide;

`ifdef NUM_REV_PAL_EN
  logic [WIDTH-1:0] op;
`else
  assign is_pal = 1'b0;
`endif

  // Digit extraction and accumulator update; division by a constant RADIX.
  always_comb begin
    x_div = x / RADIX_N;
    x_mod = x % RADIX_N;
    wide  = {5'b0, acc} * RADIX_W + {5'b0, x_mod};
  end

  // Control FSM, datapath registers and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, datapath included, is reset so an aborted run
    // leaves nothing behind; state is written with <= only so all registers
    // see the pre-edge values of each other.
    if (rst) begin
      state  <= S_IDLE;
      x      <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      digits <= '0;
      ovf    <= 1'b0;
`ifdef NUM_REV_PAL_EN
      op     <= '0;
      is_pal <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x     <= din;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
`ifdef NUM_REV_PAL_EN
            op    <= din;
`endif
            busy  <= 1'b1;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (x != '0) begin
            acc   <= wide[WIDTH-1:0];
            x     <= x_div;
            cnt   <= cnt + DIGW'(1);
            ovf_r <= ovf_r | (|wide[WW-1:WIDTH]);
          end else begin
            dout   <= acc;
            digits <= cnt;
            ovf    <= ovf_r;
`ifdef NUM_REV_PAL_EN
            is_pal <= (acc == op) && !ovf_r;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_num_reverse_engine.sv
// Directed bench for num_reverse_engine: a base-10 16-bit instance and a
// base-2 8-bit instance share clock and reset. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_num_reverse_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] din16   = '0;
  logic        busy16, done16, ovf16, pal16;
  logic [15:0] dout16;
  logic [4:0]  digits16;

  logic        start8 = 1'b0;
  logic [7:0]  din8   = '0;
  logic        busy8, done8, ovf8, pal8;
  logic [7:0]  dout8;
  logic [3:0]  digits8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  num_reverse_engine #(.WIDTH(16), .RADIX(10)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .din(din16),
    .busy(busy16), .done(done16), .dout(dout16), .digits(digits16),
    .ovf(ovf16), .is_pal(pal16)
  );

  num_reverse_engine #(.WIDTH(8), .RADIX(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .din(din8),
    .busy(busy8), .done(done8), .dout(dout8), .digits(digits8),
    .ovf(ovf8), .is_pal(pal8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected palindrome flag depends on whether the optional feature is built.
  function automatic logic pal_exp(input logic v);
`ifdef NUM_REV_PAL_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // One base-10 run: start is held through DONE, then dropped.
  // If poke is set, start pulses and din changes while busy.
  task automatic run16(input string tag, input logic [15:0] v, input int exp_lat,
                       input logic [15:0] exp_dout, input int exp_dig,
                       input logic exp_ovf, input logic exp_pal, input bit poke);
    int n;
    @(negedge clk);
    din16 = v; start16 = 1'b1;
    @(posedge clk); #1;                       // acceptance edge E0
    check({tag, " busy after E0"}, busy16, 1);
    n = 0;
    if (poke) begin
      @(negedge clk); start16 = 1'b0; din16 = 16'd9;
      @(negedge clk); start16 = 1'b1;
      @(negedge clk); start16 = 1'b0;
      @(posedge clk); #1; n = 3;
      @(negedge clk); start16 = 1'b1;
    end
    while (!done16 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy at done"}, busy16, 0);
    check({tag, " dout"}, dout16, exp_dout);
    check({tag, " digits"}, digits16, exp_dig);
    check({tag, " ovf"}, ovf16, exp_ovf);
    check({tag, " is_pal"}, pal16, pal_exp(exp_pal));
    @(posedge clk); #1;
    check({tag, " held in DONE"}, done16, 1);
    @(negedge clk); start16 = 1'b0;
    @(posedge clk); #1;
    check({tag, " back to IDLE"}, {busy16, done16}, 0);
    check({tag, " result held"}, dout16, exp_dout);
  endtask

  task automatic run8(input string tag, input logic [7:0] v, input int exp_lat,
                      input logic [7:0] exp_dout, input int exp_dig);
    int n;
    @(negedge clk);
    din8 = v; start8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, n + 0, exp_lat);
    check({tag, " dout"}, dout8, exp_dout);
    check({tag, " digits"}, digits8, exp_dig);
    check({tag, " ovf"}, ovf8, 0);
    @(posedge clk); #1;
    check({tag, " IDLE after done"}, done8, 0);
  endtask

  initial begin
    // Reset state.
    #2;
    check("reset busy16", busy16, 0);
    check("reset done16", done16, 0);
    check("reset dout16", dout16, 0);
    check("reset digits16", digits16, 0);
    check("reset ovf16", ovf16, 0);
    check("reset pal16", pal16, 0);
    check("reset dout8", dout8, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Base 10, 16 bit.
    run16("1234", 16'd1234, 5, 16'd4321, 4, 1'b0, 1'b0, 1'b0);
    run16("1200", 16'd1200, 5, 16'd21, 4, 1'b0, 1'b0, 1'b0);
    run16("zero", 16'd0, 1, 16'd0, 0, 1'b0, 1'b1, 1'b0);
    run16("19999", 16'd19999, 6, 16'd34455, 5, 1'b1, 1'b0, 1'b0);
    run16("5", 16'd5, 2, 16'd5, 1, 1'b0, 1'b1, 1'b0);
    run16("poke", 16'd1234, 5, 16'd4321, 4, 1'b0, 1'b0, 1'b1);
    run16("12321", 16'd12321, 6, 16'd12321, 5, 1'b0, 1'b1, 1'b0);
    run16("1210", 16'd1210, 5, 16'd121, 4, 1'b0, 1'b0, 1'b0);
    run16("19991", 16'd19991, 6, 16'd19991, 5, 1'b0, 1'b1, 1'b0);

    // Base 2, 8 bit.
    run8("b1101", 8'b0000_1101, 5, 8'd11, 4);
    run8("bFF", 8'hFF, 9, 8'hFF, 8);

    // Reset while stepping through 4321.
    @(negedge clk);
    din16 = 16'd4321; start16 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start16 = 1'b0;
    @(posedge clk); #1;
    check("abort busy before rst", busy16, 1);
    rst = 1'b1; #1;
    check("abort busy", busy16, 0);
    check("abort done", done16, 0);
    check("abort dout", dout16, 0);
    check("abort digits", digits16, 0);
    check("abort ovf", ovf16, 0);
    check("abort is_pal", pal16, 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("abort stays idle", {busy16, done16}, 0);
    check("abort no result", dout16, 0);

    // Fresh run after abort.
    run16("after abort", 16'd4321, 5, 16'd1234, 4, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/num_reverse_engine.md
# num_reverse_engine

Parametrised number-reversal engine: accepts an unsigned WIDTH-bit operand and returns the value whose base-RADIX digits are reversed, e.g. 1234 → 4321 in base 10. Control FSM and datapath (digit divider, accumulator, digit counter) are in one block. Overflow detection and a digit count are included. It sits behind the system start/done handshake and is the parametrised next generation of the fixed-width reverse-number controller.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- RADIX, 10, digit base (2 ≤ RADIX ≤ 16, constant)
- DIGW, $clog2(WIDTH+1), width of digit count

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  request; sampled only in IDLE
- din  in  WIDTH  operand; sampled on the edge that accepts start
- busy  out  1  high in STEP
- done  out  1  high in DONE
- dout  out  WIDTH  reversed value, low WIDTH bits
- digits  out  DIGW  number of digits processed
- ovf  out  1  sticky: reversed value exceeded 2^WIDTH−1
- is_pal  out  1  dout == operand and !ovf (only with NUM_REV_PAL_EN)

## Operation
- States: IDLE, STEP, DONE. Outputs are Moore-decoded from registers.
- IDLE, start=1:
  - x←din, acc←0, cnt←0, ovf_r←0
  - if NUM_REV_PAL_EN: op←din
  - → STEP
- IDLE, start=0: hold.
- STEP, x≠0:
  - d = x % RADIX
  - wide = acc·RADIX + d, computed at WIDTH+5 bits
  - acc ← wide[WIDTH−1:0]
  - x ← x / RADIX
  - cnt ← cnt+1
  - ovf_r ← ovf_r | (wide > 2^WIDTH−1)
- STEP, x=0: dout←acc, digits←cnt, ovf←ovf_r, is_pal updated; → DONE.
- DONE: done=1. start=0 → IDLE on the next edge; start=1 → stay in DONE.
- start in STEP or DONE is ignored; din changes after acceptance have no effect.
- Trailing zeros of din are dropped (1200 → 21). Leading zeros do not exist.
- din=0 → dout=0, digits=0, ovf=0.
- On overflow, dout equals the true reversal mod 2^WIDTH, since arithmetic truncates at every step.
- dout/digits/ovf/is_pal hold their last result until the next completion.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, dout=0, digits=0, ovf=0, is_pal=0, internal regs 0.
- Reset mid-STEP aborts with no partial result published.
- Acceptance edge E0 (IDLE, start=1): busy=1 from after E0.
- For a D-digit operand, done=1 after edge E0+D+1 and busy=0 at the same point. Outputs are valid when done rises.
- din=0 gives done after E0+1.
- Worst case D = WIDTH (RADIX=2): latency WIDTH+1.
- Return to IDLE takes one edge after start is seen low in DONE. A new start is accepted no earlier than the edge after that, so minimum start-to-start spacing is D+3 cycles.
- The x/RADIX and x%RADIX paths are single-cycle combinational at constant RADIX.

## Configuration
- NUM_REV_PAL_EN defined:
  - adds the op register and the is_pal output
  - is_pal = (dout == op) && !ovf, updated on the STEP→DONE edge
  - reset value 0
- Undefined: no op register, and is_pal is tied to 0. The port remains, so the instantiation is identical in both builds.

## Test plan
- WIDTH=16, RADIX=10, din=1234, start held → dout=4321, digits=4, ovf=0, done 5 cycles after acceptance edge; start dropped → IDLE next edge.
- din=1200 → dout=21, digits=4. din=0 → dout=0, digits=0, done after 1 cycle.
- din=19999 → ovf=1, dout=34455 (99991 mod 65536), digits=5. Next run din=5 → ovf=0, dout=5.
- WIDTH=8, RADIX=2, din=8'b0000_1101 → dout=8'd11, digits=4, latency 5. din=8'hFF → dout=8'hFF, digits=8, latency 9.
- Assert rst during STEP of din=4321 → all outputs 0, IDLE. start pulses while busy are ignored, with no restart.
- NUM_REV_PAL_EN, WIDTH=16, RADIX=10: din=12321 → is_pal=1; din=1210 → is_pal=0 (dout=121); din=19991 → is_pal=1, no overflow.
